// File: rtl/scoreboard_reporter.sv
// Scoreboard counter reporter: snapshots the counters and sends them as 8N1 bytes.
// Define SCOREBOARD_REPORTER_CHECKSUM_EN to append an XOR checksum byte.
module scoreboard_reporter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_event_ctr,
  input  logic [23:0] i_data_ctr,
  input  logic        i_req,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef SCOREBOARD_REPORTER_CHECKSUM_EN
  localparam int BW = 3;
  localparam logic [BW-1:0] LAST = 3'd4;
`else
  localparam int BW = 2;
  localparam logic [BW-1:0] LAST = 2'd3;
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, DONE
  } state_t;

  state_t        state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [2:0]    bit_q, bit_nx;
  logic [BW-1:0] byte_q, byte_nx;
  logic [31:0]   snap_q, snap_nx;
  logic          tx_q, tx_nx;
  logic          busy_q, busy_nx;
  logic          done_q, done_nx;
  logic [7:0]    cur_byte;
  logic          bit_end;

`ifdef SCOREBOARD_REPORTER_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = snap_q[31:24] ^ snap_q[23:16]
              ^ snap_q[15:8] ^ snap_q[7:0];
`endif

  // Select the byte currently being shifted out of the snapshot.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_q)
      BW'(0): cur_byte = snap_q[31:24];
      BW'(1): cur_byte = snap_q[23:16];
      BW'(2): cur_byte = snap_q[15:8];
      BW'(3): cur_byte = snap_q[7:0];
`ifdef SCOREBOARD_REPORTER_CHECKSUM_EN
      BW'(4): cur_byte = csum;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  assign bit_end = (cnt_q == CNT_MAX);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = bit_end ? '0 : cnt_q + CW'(1);
    bit_nx   = bit_q;
    byte_nx  = byte_q;
    snap_nx  = snap_q;
    tx_nx    = tx_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_nx = '0;
        if (i_req) begin
          state_nx = START;
          snap_nx  = {i_event_ctr, i_data_ctr};
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
          bit_nx   = '0;
          byte_nx  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          bit_nx   = '0;
          tx_nx    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_nx = bit_q + 3'd1;
            tx_nx  = cur_byte[bit_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_q == LAST) begin
            state_nx = DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            tx_nx    = 1'b1;
          end else begin
            state_nx = START;
            byte_nx  = byte_q + BW'(1);
            tx_nx    = 1'b0;
          end
        end
      end
      DONE: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      bit_q   <= bit_nx;
      byte_q  <= byte_nx;
      snap_q  <= snap_nx;
      tx_q    <= tx_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_scoreboard_reporter.sv
// Directed bench for scoreboard_reporter with CLKS_PER_BIT=4.
// Set SCOREBOARD_REPORTER_CHECKSUM_EN to expect the checksum byte.
module tb_scoreboard_reporter;

  localparam int CPB = 4;
`ifdef SCOREBOARD_REPORTER_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ev_i;
  logic [23:0] dt_i;
  logic        req;
  logic        tx, busy, done;

  int errs = 0;
  int checks = 0;

  scoreboard_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_event_ctr (ev_i),
    .i_data_ctr  (dt_i),
    .i_req       (req),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".tx"}, 32'(tx), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  // Starts at a negedge in IDLE; ends at a negedge back in IDLE.
  task automatic report(input logic [7:0] ev,
                        input logic [23:0] dt,
                        input bit chg,
                        input int r1,
                        input int r2,
                        input string tag);
    logic [39:0] bv;
    logic [7:0]  cb;
    logic        eb;
    int len, j, b, p;
    bv = {8'h00, dt[7:0], dt[15:8], dt[23:16], ev};
`ifdef SCOREBOARD_REPORTER_CHECKSUM_EN
    bv[39:32] = ev ^ dt[23:16] ^ dt[15:8] ^ dt[7:0];
`endif
    len = NB * 10 * CPB;
    ev_i = ev;
    dt_i = dt;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (chg && k == 0) begin
        ev_i = 8'hFF;
        dt_i = 24'hFFFFFF;
      end
      req = (k == r1 || k == r2);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".done"}, 32'(done), 32'd0);
      if (k % CPB == CPB / 2) begin
        j = k / CPB;
        b = j / 10;
        p = j % 10;
        cb = bv[b*8 +: 8];
        if (p == 0) eb = 1'b0;
        else if (p == 9) eb = 1'b1;
        else eb = cb[p-1];
        chk($sformatf("%s.tx[%0d]", tag, j), 32'(tx), 32'(eb));
      end
      @(negedge clk);
    end
    chk({tag, ".done_pulse"}, 32'(done), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".tx_end"}, 32'(tx), 32'd1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk_idle({tag, ".after"});
  endtask

  initial begin
    reset = 1'b0;
    req = 1'b0;
    ev_i = 8'h00;
    dt_i = 24'h000000;
    repeat (5) begin
      @(negedge clk);
      chk_idle("rst");
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk_idle("idle");
    end

    report(8'hA5, 24'h123456, 1'b0, -1, -1, "single");
    report(8'h01, 24'h000002, 1'b1, -1, -1, "snap");
    report(8'h3C, 24'hC3A50F, 1'b0, 10, 100, "busyign");
    report(8'h5A, 24'h0F1E2D, 1'b0, -1, -1, "rearm");

    ev_i = 8'h77;
    dt_i = 24'h665544;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (49) @(negedge clk);
    chk("mid.busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1 chk_idle("mid.async");
    repeat (3) begin
      @(negedge clk);
      chk_idle("mid.held");
    end
    reset = 1'b1;
    @(negedge clk);
    chk_idle("mid.rel");
    report(8'hC8, 24'h9ABCDE, 1'b0, -1, -1, "post");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
